// File: rtl/maze_mem_arbiter_if.sv
// Bundle between two maze walkers, the arbiter and the single-port maze memory.
// slave = arbiter view; master = walkers plus memory model driving it.
interface maze_mem_arbiter_if #(
  parameter int maze_width = 6
);
  logic                  req0;
  logic                  req1;
  logic                  lock0;
  logic                  lock1;
  logic [maze_width-1:0] row0;
  logic [maze_width-1:0] col0;
  logic [maze_width-1:0] row1;
  logic [maze_width-1:0] col1;
  logic                  we0;
  logic                  we1;
  logic                  ack0;
  logic                  ack1;
  logic                  rdata0;
  logic                  rdata1;
  logic [maze_width-1:0] row;
  logic [maze_width-1:0] col;
  logic                  maze_oe;
  logic                  maze_we;
  logic                  maze_in;
  logic                  busy;

  modport slave (
    input  req0, req1, lock0, lock1, row0, col0, row1, col1, we0, we1, maze_in,
    output ack0, ack1, rdata0, rdata1, row, col, maze_oe, maze_we, busy
  );

  modport master (
    output req0, req1, lock0, lock1, row0, col0, row1, col1, we0, we1, maze_in,
    input  ack0, ack1, rdata0, rdata1, row, col, maze_oe, maze_we, busy
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin two-client arbiter for the maze memory port; req->strobe 1 cycle, req->ack 2 cycles.
// Clients hold req until ack; a losing client simply waits, one access in flight at a time.
module maze_mem_arbiter #(
  parameter int maze_width = 6
) (
  input logic               clk,
  input logic               rst_n,
  maze_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [maze_width-1:0] row;
    logic [maze_width-1:0] col;
    logic                  we;
    logic                  lock;
  } req_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_lock_vld;
  logic                  r_lock_owner;
  logic                  r_lock_lat;
  logic                  r_winner;
  logic [maze_width-1:0] r_row;
  logic [maze_width-1:0] r_col;
  logic                  r_oe;
  logic                  r_we;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_rdata0;
  logic                  r_rdata1;
  logic                  r_busy;

  req_t w_req0;
  req_t w_req1;
  req_t w_sel;
  logic w_owner_req;
  logic w_lock_hit;
  logic w_winner;
  logic w_any_req;

  assign w_req0      = {bus.row0, bus.col0, bus.we0, bus.lock0};
  assign w_req1      = {bus.row1, bus.col1, bus.we1, bus.lock1};
  assign w_any_req   = bus.req0 | bus.req1;
  assign w_owner_req = r_lock_owner ? bus.req1 : bus.req0;
  // A lock only holds while its owner is actually asking again; otherwise it lapses.
  assign w_lock_hit  = r_lock_vld & w_owner_req;

  always_comb begin
    w_winner = ~r_last_grant;
    if (w_lock_hit) begin
      w_winner = r_lock_owner;
    end else if (bus.req0 & ~bus.req1) begin
      w_winner = 1'b0;
    end else if (bus.req1 & ~bus.req0) begin
      w_winner = 1'b1;
    end
  end

  assign w_sel = w_winner ? w_req1 : w_req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_lock_vld   <= 1'b0;
      r_lock_owner <= 1'b0;
      r_lock_lat   <= 1'b0;
      r_winner     <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_oe         <= 1'b0;
      r_we         <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= 1'b0;
      r_rdata1     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_lock_vld && !w_owner_req) begin
            r_lock_vld <= 1'b0;
          end
          if (w_any_req) begin
            r_winner   <= w_winner;
            r_row      <= w_sel.row;
            r_col      <= w_sel.col;
            r_oe       <= ~w_sel.we;
            r_we       <= w_sel.we;
            r_lock_lat <= w_sel.lock;
            r_busy     <= 1'b1;
            r_state    <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // r_we still holds the latched direction here; it clears on this same edge.
          if (!r_we) begin
            if (r_winner) begin
              r_rdata1 <= bus.maze_in;
            end else begin
              r_rdata0 <= bus.maze_in;
            end
          end
          r_oe         <= 1'b0;
          r_we         <= 1'b0;
          r_ack0       <= ~r_winner;
          r_ack1       <= r_winner;
          r_last_grant <= r_winner;
          r_lock_vld   <= r_lock_lat;
          r_lock_owner <= r_winner;
          r_state      <= ST_RESP;
        end

        ST_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_oe    <= 1'b0;
          r_we    <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.row     = r_row;
  assign bus.col     = r_col;
  assign bus.maze_oe = r_oe;
  assign bus.maze_we = r_we;
  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign bus.busy    = r_busy;

endmodule
